// File: rtl/inc_dec_pkg.sv
// inc_dec_pkg: op encodings, buffer occupancy type and default parameters for inc_dec_unit
package inc_dec_pkg;
  localparam logic OP_INC = 1'b0;
  localparam logic OP_DEC = 1'b1;
  localparam int DEF_WIDTH = 4;
  localparam int unsigned DEF_STEP = 1;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
endpackage

// File: rtl/inc_dec_unit_if.sv
// inc_dec_unit_if: operand/result handshake bus of inc_dec_unit
interface inc_dec_unit_if import inc_dec_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic in_valid;
  logic in_ready;
  logic op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH:0] a_res;
  logic [WIDTH:0] b_res;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, a_res, b_res);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, a_res, b_res);
endinterface

// File: rtl/inc_dec_lane.sv
// inc_dec_lane: one lane of x +/- STEP; INC_DEC_SAT_EN selects clamping instead of wrap-around
module inc_dec_lane import inc_dec_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int unsigned STEP = DEF_STEP
) (
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH:0]   y
);
  logic [WIDTH:0] raw;
  assign raw = op == OP_DEC ? {1'b0, x} - (WIDTH+1)'(STEP) : {1'b0, x} + (WIDTH+1)'(STEP);
`ifdef INC_DEC_SAT_EN
  // carry/borrow means the true result left the range: pin to the bound
  assign y = raw[WIDTH] ? {1'b1, {WIDTH{op == OP_INC}}} : raw;
`else
  assign y = raw;
`endif
endmodule

// File: rtl/inc_dec_unit.sv
// inc_dec_unit: two-lane inc/dec by STEP with 2-entry result FIFO and saturating overflow counter (INC_DEC_SAT_EN: clamp mode)
module inc_dec_unit import inc_dec_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int unsigned STEP = DEF_STEP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  inc_dec_unit_if.slave    bus,
  output logic [CNT_W-1:0] ovf_cnt
);
  logic [WIDTH:0] a_nxt, b_nxt;
  logic [WIDTH:0] mem_a [2];
  logic [WIDTH:0] mem_b [2];
  logic wr_ptr, rd_ptr, push, pop;
  logic [1:0] ovf_inc;
  logic [CNT_W+1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;
  occ_t occ, occ_nxt;
  inc_dec_lane #(.WIDTH(WIDTH), .STEP(STEP)) u_lane_a (.op(bus.op), .x(bus.a), .y(a_nxt));
  inc_dec_lane #(.WIDTH(WIDTH), .STEP(STEP)) u_lane_b (.op(bus.op), .x(bus.b), .y(b_nxt));
  // in_ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready = occ != FULL;
  assign bus.out_valid = occ != EMPTY;
  assign bus.a_res = mem_a[rd_ptr];
  assign bus.b_res = mem_b[rd_ptr];
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  always_comb begin
    ovf_inc = {1'b0, a_nxt[WIDTH]} + {1'b0, b_nxt[WIDTH]};
    cnt_sum = {2'b00, ovf_cnt} + {{CNT_W{1'b0}}, ovf_inc};
    cnt_nxt = cnt_sum[CNT_W+1:CNT_W] != 2'b00 ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    occ_nxt = push && !pop ? (occ == EMPTY ? ONE : FULL) :
              pop && !push ? (occ == FULL ? ONE : EMPTY) : occ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem_a[0] <= '0;
      mem_a[1] <= '0;
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      ovf_cnt <= '0;
    end else begin
      occ <= occ_nxt;
      if (push) begin
        mem_a[wr_ptr] <= a_nxt;
        mem_b[wr_ptr] <= b_nxt;
        wr_ptr <= ~wr_ptr;
        ovf_cnt <= cnt_nxt;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
endmodule

// File: tb/tb_inc_dec_unit.sv
// tb_inc_dec_unit: directed self-checking bench for inc_dec_unit (default and CNT_W=2 instances)
module tb_inc_dec_unit;
  import inc_dec_pkg::*;
`ifdef INC_DEC_SAT_EN
  localparam logic [4:0] A_F_INC = 5'h1F;
  localparam logic [4:0] A_0_DEC = 5'h10;
`else
  localparam logic [4:0] A_F_INC = 5'h10;
  localparam logic [4:0] A_0_DEC = 5'h1F;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ovf;
  logic [1:0] ovf2;
  int checks = 0;
  int errors = 0;
  inc_dec_unit_if #(.WIDTH(4)) bus ();
  inc_dec_unit_if #(.WIDTH(4)) bus2 ();
  inc_dec_unit #(.WIDTH(4), .STEP(1), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus), .ovf_cnt(ovf));
  inc_dec_unit #(.WIDTH(4), .STEP(1), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .ovf_cnt(ovf2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.in_valid = 1'b1;
    bus.op = OP_INC;
    bus.a = 4'hF;
    bus.b = 4'hF;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.op = OP_INC;
    bus2.a = 4'h0;
    bus2.b = 4'h0;
    bus2.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_a_res", {27'd0, bus.a_res}, 32'd0);
    check("rst_b_res", {27'd0, bus.b_res}, 32'd0);
    check("rst_ovf", {24'd0, ovf}, 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.op = OP_INC;
    bus.a = 4'hF;
    bus.b = 4'h3;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("inc_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("inc_a_res", {27'd0, bus.a_res}, {27'd0, A_F_INC});
    check("inc_b_res", {27'd0, bus.b_res}, 32'h04);
    check("inc_ovf", {24'd0, ovf}, 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("inc_drained", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b1;
    bus.op = OP_DEC;
    bus.a = 4'h0;
    bus.b = 4'h5;
    @(negedge clk);
    check("dec_a_res", {27'd0, bus.a_res}, {27'd0, A_0_DEC});
    check("dec_b_res", {27'd0, bus.b_res}, 32'h04);
    check("dec_ovf", {24'd0, ovf}, 32'd2);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("dec_drained", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = OP_INC;
    bus.a = 4'h1;
    bus.b = 4'h2;
    @(negedge clk);
    check("one_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.a = 4'h3;
    bus.b = 4'h4;
    @(negedge clk);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full_head_a", {27'd0, bus.a_res}, 32'h02);
    bus.a = 4'h5;
    bus.b = 4'h6;
    @(negedge clk);
    check("full_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full_hold_a", {27'd0, bus.a_res}, 32'h02);
    check("full_hold_b", {27'd0, bus.b_res}, 32'h03);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("order2_a", {27'd0, bus.a_res}, 32'h04);
    check("order2_b", {27'd0, bus.b_res}, 32'h05);
    check("order2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    check("simul_a", {27'd0, bus.a_res}, 32'h06);
    check("simul_b", {27'd0, bus.b_res}, 32'h07);
    check("simul_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("simul_drained", {31'd0, bus.out_valid}, 32'd0);
    check("ovf_unchanged", {24'd0, ovf}, 32'd2);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 4'h7;
    bus.b = 4'h8;
    @(negedge clk);
    bus.a = 4'h9;
    bus.b = 4'hA;
    @(negedge clk);
    check("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    bus.a = 4'hF;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_ovf", {24'd0, ovf}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("no_partial_out", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b1;
    bus.a = 4'hF;
    bus.b = 4'hF;
    @(negedge clk);
    check("dual_ovf", {24'd0, ovf}, 32'd2);
    check("dual_b_res", {27'd0, bus.b_res}, {27'd0, A_F_INC});
    bus.in_valid = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.a = 4'hF;
    bus2.b = 4'h0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("sat_cnt_%0d", i), {30'd0, ovf2}, (i > 3) ? 32'd3 : 32'(i));
    end
    bus2.in_valid = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
